if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the RISC-V core. Owns the PC register and drives the synchronous-read instruction memory. Presents a PC/instruction pair with a valid flag to the decode stage, whose control decoder consumes `id_inst`. Also handles decode-stage stalls, redirects from execute (taken branches, JAL, JALR) and a retired-fetch counter.

## Interface
- `RESET_PC`, 32'h4000_0000, first fetch address after reset (BIOS base)
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `stall` in 1: hazard unit; hold the decode-stage instruction and the PC
- `redirect_valid` in 1: execute stage resolved a control transfer; fetch restarts at `redirect_pc`
- `redirect_pc` in 32: target address; bits [1:0] are ignored and treated as 0
- `imem_en` out 1: instruction-memory read enable
- `imem_addr` out 32: instruction-memory byte address, word aligned
- `imem_rdata` in 32: read data for the address issued on the previous cycle
- `id_pc` out 32: PC of the instruction presented to decode
- `id_inst` out 32: instruction presented to decode; NOP (32'h0000_0013) whenever `id_valid`=0
- `id_valid` out 1: `id_pc`/`id_inst` hold a real, non-killed instruction
- `fetch_count` out 32: number of instructions accepted by decode since reset

## Operation
State:
- `pc_q`: PC of the instruction currently at decode.
- `v_q`: a fetch is outstanding for `pc_q`.
- `buf_valid`/`buf_inst`: holding register.
- `fetch_count`.

Next-PC `npc`, in priority order:
- `redirect_valid`: `{redirect_pc[31:2],2'b00}`.
- `stall`: `pc_q`.
- `!v_q`: `pc_q`. This is the first fetch after reset.
- otherwise: `pc_q + 4`. Wraps modulo 2^32.

Outputs and register updates:
- `imem_addr = npc`.
- `imem_en = rst_n && (redirect_valid || !stall)`.
- `pc_q <= npc` every cycle.
- `v_q <= 1` every cycle.
- `id_inst = buf_valid ? buf_inst : imem_rdata`, forced to NOP when `id_valid`=0.
- `id_valid = v_q && !redirect_valid`. A redirect kills the instruction currently at decode in the same cycle.

Holding register:
- On any cycle with `stall && !redirect_valid && !buf_valid`: `buf_inst <= imem_rdata` and `buf_valid <= 1`. The memory output is not assumed to persist while `imem_en`=0.
- `buf_valid` clears on the first cycle with `!stall`, or on any cycle with `redirect_valid`.

`fetch_count` increments on every cycle with `id_valid && !stall`.

Simultaneous events:
- `redirect_valid` and `stall` together: the redirect wins. The memory is read at the target and the buffer is cleared.

Reset:
- Reset values: `pc_q`=`RESET_PC`, `v_q`=0, `buf_valid`=0, `buf_inst`=NOP, `fetch_count`=0.
- While `rst_n`=0: `imem_en`=0, `id_valid`=0.
- Reset asserted mid-stall or mid-redirect discards all in-flight state at that edge.

## Timing
- Fetch latency: an address issued in cycle N appears at decode in cycle N+1 with `id_pc` equal to that address.
- First cycle after reset release: `imem_addr`=`RESET_PC`, `id_valid`=0.
- Second cycle after reset release: `id_pc`=`RESET_PC`, `id_valid`=1.
- Redirect in cycle N: `id_valid`=0 in cycle N. The target appears at decode in N+1.
- Branch penalty: the execute-stage block must itself squash the instruction it holds, if required.
- Stall: outputs are held constant for every stalled cycle. On the first unstalled cycle the held instruction is accepted and `pc_q+4` is issued. Throughput is one instruction per cycle with no stall.
- No combinational path from `imem_rdata` to `imem_addr`. `redirect_valid`, `redirect_pc` and `stall` reach `imem_addr` combinationally.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Structure
- Shared header `fetch_defs.vh` holds `INST_NOP` (32'h0000_0013) and the default `RESET_PC`. It sits alongside `opcode.vh`.
- Sub-module `if_inst_buf` contains the holding register: capture, clear and output mux for `id_inst`.
- The PC, next-PC mux and counter stay in `if_stage`.

## Test plan
- Reset, then free-run with a memory model returning `inst = addr`:
  - Cycle 1 after reset: `imem_addr`=32'h4000_0000, `id_valid`=0.
  - Subsequent cycles: `id_pc`/`id_inst` equal 32'h4000_0000, 32'h4000_0004, … on consecutive cycles.
  - After 10 cycles, `fetch_count`=10.
- 3-cycle stall while `id_pc`=32'h4000_0008:
  - During the stall: `id_inst` stays 32'h4000_0008, `imem_en`=0, `fetch_count` is frozen. The memory model drives garbage while disabled.
  - The next instruction is 32'h4000_000C, with no duplicates or skips.
- Redirect to 32'h4000_0100 in cycle N:
  - `id_valid`=0 in cycle N.
  - `id_pc`=32'h4000_0100, `id_valid`=1 in N+1.
  - 32'h4000_0104 in N+2.
- `redirect_valid` and `stall` together, with target 32'h4000_0203:
  - The redirect wins, `imem_en`=1, `imem_addr`=32'h4000_0200.
  - The buffer is empty at N+1.
- Reset asserted during a stall with the buffer full: the next cycle shows `id_valid`=0 and `fetch_count`=0. Fetch restarts at `RESET_PC`.
- Force `fetch_count` to 32'hFFFF_FFFF, then accept one instruction: the count becomes 0.
- Run PC up to 32'hFFFF_FFFC: the next fetch is at 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: the NOP encoding, the default boot address and
// a helper that forces an address onto a word boundary.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t INST_NOP     = 32'h0000_0013;
  localparam word_t RESET_PC_DEF = 32'h4000_0000;

  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Holding register for the instruction at decode. It captures the memory output on
// the first stalled cycle, because the memory is not read again while stalled.
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  stall_i,
  input  logic  redirect_i,
  input  logic  valid_i,
  input  word_t rdata_i,
  output word_t inst_o
);

  logic  buf_valid_q, buf_valid_d;
  word_t buf_inst_q, buf_inst_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (stall_i && !redirect_i && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = rdata_i;
    end else if (!stall_i || redirect_i) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_valid_q <= 1'b0;
      buf_inst_q  <= INST_NOP;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  // Killed or empty slots must present a NOP to the control decoder.
  assign inst_o = !valid_i    ? INST_NOP   :
                  buf_valid_q ? buf_inst_q : rdata_i;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, synchronous-read
// instruction memory interface, decode-stage stall handling and accepted-fetch counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output logic  imem_en,
  output word_t imem_addr,
  input  word_t imem_rdata,
  output word_t id_pc,
  output word_t id_inst,
  output logic  id_valid,
  output word_t fetch_count
);

  word_t pc_q, pc_d;
  logic  v_q;
  word_t fetch_count_q, fetch_count_d;

  // Redirect beats stall; a hold also covers the very first fetch after reset.
  always_comb begin
    if (redirect_valid)    pc_d = align_word(redirect_pc);
    else if (stall || !v_q) pc_d = pc_q;
    else                   pc_d = pc_q + 32'd4;
  end

  assign imem_addr = pc_d;
  assign imem_en   = rst_n && (redirect_valid || !stall);
  assign id_valid  = rst_n && v_q && !redirect_valid;
  assign id_pc     = pc_q;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (id_valid && !stall) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      v_q           <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      v_q           <= 1'b1;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;

  if_inst_buf u_buf (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .stall_i    (stall),
    .redirect_i (redirect_valid),
    .valid_i    (id_valid),
    .rdata_i    (imem_rdata),
    .inst_o     (id_inst)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory returns inst = addr, so every real instruction at decode
// must equal its own PC; a transaction-level model predicts outputs each cycle.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam word_t RPC = 32'h4000_0000;
  localparam word_t NOP = 32'h0000_0013;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  stall = 1'b0;
  logic  redirect_valid = 1'b0;
  word_t redirect_pc = '0;
  logic  imem_en;
  word_t imem_addr;
  word_t imem_rdata = '0;
  word_t id_pc, id_inst, fetch_count;
  logic  id_valid;

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_valid       (id_valid),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: word at address A holds A; garbage appears whenever the read is disabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr;
    else         imem_rdata <= 32'hBAD0_0000 | word_t'($urandom_range(0, 65535));
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: decode slot holds instruction m_pc when m_has; a counter of accepted fetches.
  word_t m_pc    = RPC;
  logic  m_has   = 1'b0;
  word_t m_count = '0;
  int    ovr_seq  = 0;
  int    ovr_seen = 0;

  function automatic word_t next_fetch();
    if (redirect_valid)      return {redirect_pc[31:2], 2'b00};
    if (stall || !m_has)     return m_pc;
    return m_pc + 32'd4;
  endfunction

  function automatic logic m_valid();
    return rst_n && m_has && !redirect_valid;
  endfunction

  always @(posedge clk) begin
    word_t cnt;
    cnt = (ovr_seq != ovr_seen) ? 32'hFFFF_FFFF : m_count;
    ovr_seen = ovr_seq;
    if (!rst_n) begin
      m_pc = RPC; m_has = 1'b0; m_count = '0;
    end else begin
      if (m_valid() && !stall) cnt = cnt + 32'd1;
      m_count = cnt;
      m_pc    = next_fetch();
      m_has   = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
      chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    end else begin
      chk("m_id_valid", {31'b0, id_valid}, {31'b0, m_valid()});
      chk("m_imem_en", {31'b0, imem_en}, {31'b0, redirect_valid || !stall});
      chk("m_imem_addr", imem_addr, next_fetch());
      chk("m_id_pc", id_pc, m_pc);
      chk("m_id_inst", id_inst, m_valid() ? m_pc : NOP);
      if (ovr_seq == ovr_seen) chk("m_fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    word_t c0;
    cyc(); cyc();
    reset_dut();
    // First cycle after release.
    chk("c1_imem_addr", imem_addr, 32'h4000_0000);
    chk("c1_id_valid", {31'b0, id_valid}, 32'd0);
    chk("c1_id_inst_nop", id_inst, NOP);
    chk("c1_count", fetch_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("run_id_pc", id_pc, 32'h4000_0000 + word_t'(i) * 32'd4);
      chk("run_id_inst", id_inst, 32'h4000_0000 + word_t'(i) * 32'd4);
    end
    cyc();
    chk("count_10", fetch_count, 32'd10);

    // Stall at 0x4000_0008.
    reset_dut();
    cyc(); cyc(); cyc();
    chk("pre_stall_pc", id_pc, 32'h4000_0008);
    c0 = fetch_count;
    chk("pre_stall_count", c0, 32'd2);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_id_inst", id_inst, 32'h4000_0008);
      chk("stall_id_pc", id_pc, 32'h4000_0008);
      chk("stall_imem_en", {31'b0, imem_en}, 32'd0);
      chk("stall_count", fetch_count, 32'd2);
      if (i < 2) begin cyc(); #1; end
    end
    cyc();
    stall = 1'b0;
    #1;
    chk("unstall_inst", id_inst, 32'h4000_0008);
    chk("unstall_addr", imem_addr, 32'h4000_000C);
    cyc();
    chk("after_stall_pc", id_pc, 32'h4000_000C);
    chk("after_stall_inst", id_inst, 32'h4000_000C);
    chk("after_stall_count", fetch_count, 32'd3);

    // Redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h4000_0100;
    #1;
    chk("redir_kill", {31'b0, id_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h4000_0100);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("redir_n1_pc", id_pc, 32'h4000_0100);
    chk("redir_n1_valid", {31'b0, id_valid}, 32'd1);
    chk("redir_n1_inst", id_inst, 32'h4000_0100);
    cyc();
    chk("redir_n2_pc", id_pc, 32'h4000_0104);

    // Redirect together with stall, unaligned target.
    redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h4000_0203;
    #1;
    chk("rs_imem_en", {31'b0, imem_en}, 32'd1);
    chk("rs_imem_addr", imem_addr, 32'h4000_0200);
    cyc();
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    chk("rs_buf_empty", {31'b0, dut.u_buf.buf_valid_q}, 32'd0);
    chk("rs_id_pc", id_pc, 32'h4000_0200);
    chk("rs_id_inst", id_inst, 32'h4000_0200);

    // Reset during a stall with the buffer full.
    cyc();
    stall = 1'b1;
    cyc();
    chk("rst_stall_buf_full", {31'b0, dut.u_buf.buf_valid_q}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_en", {31'b0, imem_en}, 32'd0);
    cyc();
    chk("rst_after_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_after_count", fetch_count, 32'd0);
    stall = 1'b0; rst_n = 1'b1;
    #1;
    chk("rst_restart_addr", imem_addr, RPC);
    cyc();
    chk("rst_restart_pc", id_pc, RPC);
    chk("rst_restart_valid", {31'b0, id_valid}, 32'd1);

    // Counter wrap.
    ovr_seq = ovr_seq + 1;
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count_q;
    cyc();
    chk("count_wrap", fetch_count, 32'd0);

    // PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("pcw_fff8", id_pc, 32'hFFFF_FFF8);
    cyc();
    chk("pcw_fffc", id_pc, 32'hFFFF_FFFC);
    chk("pcw_next_addr", imem_addr, 32'h0000_0000);
    cyc();
    chk("pcw_zero_pc", id_pc, 32'h0000_0000);
    chk("pcw_zero_inst", id_inst, 32'h0000_0000);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
